// File: rtl/keycode_pkg.sv
// Shared types and the HID keycode-to-direction map for the keycode move scheduler.
package keycode_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        LEFT  = 2'd1,
        DOWN  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_D = 8'h07;

    typedef struct packed {
        logic hit;
        dir_t dir;
    } key_map_t;

    function automatic key_map_t map_key(input logic [7:0] code);
        key_map_t m;
        m.hit = 1'b1;
        m.dir = UP;
        case (code)
            KEY_W:   m.dir = UP;
            KEY_A:   m.dir = LEFT;
            KEY_S:   m.dir = DOWN;
            KEY_D:   m.dir = RIGHT;
            default: m.hit = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/keycode_move_sched_if.sv
// Movement-command handshake between the scheduler (master) and the sprite movement controller (slave).
interface keycode_move_sched_if;
    import keycode_pkg::*;

    // A beat transfers on a clock edge where move_valid && move_ready; move_dir holds while valid && !ready.
    logic       move_valid;
    logic       move_ready;
    dir_t       move_dir;
    rep_state_t rep_state;

    modport master (
        output move_valid,
        output move_dir,
        output rep_state,
        input  move_ready
    );

    modport slave (
        input  move_valid,
        input  move_dir,
        input  rep_state,
        output move_ready
    );

endinterface

// File: rtl/move_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module move_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;
    logic             do_push;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/keycode_move_sched.sv
// Turns keycode PIO values into queued movement commands: press-edge detection, frame-paced auto-repeat, FIFO.
module keycode_move_sched
    import keycode_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int REPEAT_DELAY = 12,
    parameter int REPEAT_RATE  = 6
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [7:0]                  keycode,
    input  logic                        frame_tick,
    input  logic                        clr_overflow,
    keycode_move_sched_if.master        bus,
    output logic                        held_dir_valid,
    output logic [$clog2(DEPTH):0]      fifo_count,
    output logic                        overflow
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    rep_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       prev_key;
    dir_t             held_dir;
    logic             push_q;
    dir_t             push_dir_q;
    key_map_t         key_now;
    logic             key_changed;
    logic             fifo_full;
    logic             fifo_empty;
    logic [1:0]       head;
    logic             drop;

    assign key_now     = map_key(keycode);
    assign key_changed = (keycode != prev_key);

    // Pushes are registered, so a press reaches the FIFO one cycle after the keycode changes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_key   <= 8'h00;
            state      <= IDLE;
            cnt        <= '0;
            held_dir   <= UP;
            push_q     <= 1'b0;
            push_dir_q <= UP;
        end else begin
            prev_key <= keycode;
            push_q   <= 1'b0;
            if (key_changed) begin
                cnt <= '0;
                if (key_now.hit) begin
                    state      <= DELAY;
                    held_dir   <= key_now.dir;
                    push_q     <= 1'b1;
                    push_dir_q <= key_now.dir;
                end else begin
                    state <= IDLE;
                end
            end else if (frame_tick) begin
                case (state)
                    DELAY: begin
                        if (cnt == CNT_W'(REPEAT_DELAY - 1)) begin
                            cnt        <= '0;
                            state      <= REPEAT;
                            push_q     <= 1'b1;
                            push_dir_q <= held_dir;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (cnt == CNT_W'(REPEAT_RATE - 1)) begin
                            cnt        <= '0;
                            push_q     <= 1'b1;
                            push_dir_q <= held_dir;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: cnt <= '0;
                endcase
            end
        end
    end

    move_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_q),
        .push_data (push_dir_q),
        .pop       (bus.move_ready),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // When full, a pop is always possible, so only a push without a ready consumer is lost.
    assign drop = push_q && fifo_full && !bus.move_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    assign bus.move_valid  = !fifo_empty;
    assign bus.move_dir    = dir_t'(head);
    assign bus.rep_state   = state;
    assign held_dir_valid  = (state != IDLE);

endmodule

// File: tb/tb_keycode_move_sched.sv
// Randomized and directed stimulus for keycode_move_sched, checked against a queue-based reference model.
module tb_keycode_move_sched;

    localparam int DEPTH = 4;
    localparam int RD    = 12;
    localparam int RR    = 6;

    logic       clk;
    logic       reset_n;
    logic [7:0] keycode;
    logic       frame_tick;
    logic       clr_overflow;
    logic       held_dir_valid;
    logic [2:0] fifo_count;
    logic       overflow;

    keycode_move_sched_if bus ();

    keycode_move_sched #(
        .DEPTH        (DEPTH),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .keycode        (keycode),
        .frame_tick     (frame_tick),
        .clr_overflow   (clr_overflow),
        .bus            (bus),
        .held_dir_valid (held_dir_valid),
        .fifo_count     (fifo_count),
        .overflow       (overflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int beats  = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: ticks since press decides repeats; a pending push lands one cycle later
    logic [1:0] exp_q[$];
    logic [7:0] m_prev;
    int         m_ticks;
    bit         m_held;
    int         m_held_dir;
    bit         m_pend;
    int         m_pend_dir;
    int         m_count;
    bit         m_ovf;

    function automatic bit tb_map(input logic [7:0] c, output int d);
        d = 0;
        case (c)
            8'h1A: d = 0;
            8'h04: d = 1;
            8'h16: d = 2;
            8'h07: d = 3;
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_prev = 8'h00; m_ticks = 0; m_held = 0; m_held_dir = 0;
        m_pend = 0; m_pend_dir = 0; m_count = 0; m_ovf = 0;
    endtask

    task automatic model_step();
        bit pop;
        bit new_pend;
        int new_dir;
        int d;
        pop = (m_count != 0) && bus.move_ready;
        if (m_pend && m_count == DEPTH && !pop) begin
            m_ovf = 1;
        end else begin
            if (m_pend) begin
                exp_q.push_back(2'(m_pend_dir));
                m_count++;
            end
            if (clr_overflow) m_ovf = 0;
        end
        if (pop) m_count--;
        new_pend = 0;
        new_dir  = 0;
        if (keycode != m_prev) begin
            m_ticks = 0;
            if (tb_map(keycode, d)) begin
                m_held = 1; m_held_dir = d; new_pend = 1; new_dir = d;
            end else begin
                m_held = 0;
            end
        end else if (frame_tick && m_held) begin
            m_ticks++;
            if (m_ticks == RD || (m_ticks > RD && (m_ticks - RD) % RR == 0)) begin
                new_pend = 1; new_dir = m_held_dir;
            end
        end
        m_prev     = keycode;
        m_pend     = new_pend;
        m_pend_dir = new_dir;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    // scoreboard monitor, sampled on the falling edge
    initial begin
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                check("move_valid", bus.move_valid, int'(m_count != 0));
                check("fifo_count", fifo_count, m_count);
                check("overflow", overflow, m_ovf);
                check("held_dir_valid", held_dir_valid, m_held);
                if (bus.move_valid && bus.move_ready) begin
                    beats++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("move_dir", bus.move_dir, e);
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_seq(input logic [7:0] k);
        keycode = k;
        step(2);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step(1);
            frame_tick = 1'b0;
            step(2);
        end
    endtask

    logic [7:0] keys [6];
    int         beats_before;

    initial begin
        keys = '{8'h00, 8'h1A, 8'h04, 8'h16, 8'h07, 8'h05};
        reset_n = 1'b0; keycode = 8'h00; frame_tick = 1'b0; clr_overflow = 1'b0;
        bus.move_ready = 1'b0;
        step(3);
        check("reset_valid", bus.move_valid, 0);
        check("reset_count", fifo_count, 0);
        check("reset_overflow", overflow, 0);
        check("reset_held", held_dir_valid, 0);
        check("reset_dir", bus.move_dir, 0);
        reset_n = 1'b1;
        step(2);

        // single press, no ticks: exactly one beat
        bus.move_ready = 1'b1;
        beats_before = beats;
        keycode = 8'h1A;
        step(8);
        check("single_press_beats", beats - beats_before, 1);

        // held right with 30 ticks: press + 4 repeats
        keycode = 8'h00; step(2);
        beats_before = beats;
        keycode = 8'h07; step(2);
        ticks(30);
        step(3);
        check("repeat_beats", beats - beats_before, 5);

        // fill without a consumer; fifth press is dropped
        keycode = 8'h00; step(4);
        bus.move_ready = 1'b0;
        press_seq(8'h04); press_seq(8'h00); press_seq(8'h16); press_seq(8'h00);
        press_seq(8'h1A); press_seq(8'h00); press_seq(8'h07); press_seq(8'h00);
        keycode = 8'h04;
        step(3);
        check("full_count", fifo_count, 4);
        check("full_overflow", overflow, 1);
        clr_overflow = 1'b1; step(1); clr_overflow = 1'b0; step(1);

        // push and pop in the same cycle while full
        keycode = 8'h16; step(1);
        bus.move_ready = 1'b1; step(1);
        bus.move_ready = 1'b0; step(1);
        check("pushpop_count", fifo_count, 4);
        check("pushpop_overflow", overflow, 0);
        bus.move_ready = 1'b1; keycode = 8'h00; step(8);

        // up held 11 ticks then switched to down; down repeats after a fresh delay
        beats_before = beats;
        keycode = 8'h1A; step(2);
        ticks(11);
        keycode = 8'h16; step(2);
        ticks(12);
        step(3);
        check("switch_beats", beats - beats_before, 3);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) keycode = keys[$urandom_range(0, 5)];
            frame_tick     = ($urandom_range(0, 2) == 0);
            bus.move_ready = ($urandom_range(0, 1) == 0);
            clr_overflow   = ($urandom_range(0, 19) == 0);
            step(1);
        end
        frame_tick = 1'b0; clr_overflow = 1'b0;
        keycode = 8'h00; bus.move_ready = 1'b1;
        step(10);

        // reset mid-DELAY with three entries queued, key held across release
        bus.move_ready = 1'b0;
        press_seq(8'h04); press_seq(8'h00); press_seq(8'h16); press_seq(8'h00);
        keycode = 8'h1A; step(2);
        ticks(3);
        check("pre_reset_count", fifo_count, 3);
        #2 reset_n = 1'b0;
        keycode = 8'h04;
        #1;
        check("async_reset_valid", bus.move_valid, 0);
        check("async_reset_count", fifo_count, 0);
        check("async_reset_held", held_dir_valid, 0);
        step(3);
        #2 reset_n = 1'b1;
        bus.move_ready = 1'b1;
        beats_before = beats;
        step(10);
        check("post_reset_beats", beats - beats_before, 1);
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
